// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler tick, per-channel OFF/ON/BLINK/BREATHE.
// Ports: sys_clk/sys_reset_n (sync, active low); cfg_valid/cfg_ready/cfg_chan/cfg_mode/cfg_half
//   configuration write port; tick timebase pulse; led pins (polarity set by ACTIVE_LOW).
// Latency: led registered one cycle after channel state; cfg_ready held high once out of reset.
module led_pattern_gen #(
  parameter int NUM_LEDS     = 6,
  parameter int CLK_HZ       = 27000000,
  parameter int TICK_HZ      = 1000,
  parameter int DIV_W        = 16,
  parameter int PWM_BITS     = 8,
  parameter int DEFAULT_HALF = 500,
  parameter int ACTIVE_LOW   = 1,
  localparam int CW          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                sys_clk,
  input  logic                sys_reset_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [DIV_W-1:0]    cfg_half,
  output logic                tick,
  output logic [NUM_LEDS-1:0] led
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = $clog2(PRESCALE);

  localparam logic                INACTIVE = 1'(ACTIVE_LOW);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);
  localparam logic [DIV_W-1:0]    HALF_ONE = DIV_W'(1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;

  mode_e               mode     [NUM_LEDS];
  logic [DIV_W-1:0]    half     [NUM_LEDS];
  logic [DIV_W-1:0]    cnt      [NUM_LEDS];
  logic [PWM_BITS-1:0] duty     [NUM_LEDS];
  logic                phase    [NUM_LEDS];
  logic                dir_down [NUM_LEDS];

  logic [NUM_LEDS-1:0] cfg_hit;
  logic [NUM_LEDS-1:0] lit;
  logic [DIV_W-1:0]    cfg_half_eff;

  // Out-of-range channel numbers match no cfg_hit bit, so such writes are
  // accepted by the handshake but change nothing.
  always_comb begin
    cfg_hit      = '0;
    lit          = '0;
    cfg_half_eff = (cfg_half == '0) ? HALF_ONE : cfg_half;
    for (int i = 0; i < NUM_LEDS; i++) begin
      cfg_hit[i] = cfg_valid && cfg_ready && (cfg_chan == CW'(i));
      case (mode[i])
        MODE_OFF:     lit[i] = 1'b0;
        MODE_ON:      lit[i] = 1'b1;
        MODE_BLINK:   lit[i] = phase[i];
        MODE_BREATHE: lit[i] = (pwm_cnt < duty[i]);
        default:      lit[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      pre_cnt   <= '0;
      pwm_cnt   <= '0;
      tick      <= 1'b0;
      cfg_ready <= 1'b0;
      led       <= {NUM_LEDS{INACTIVE}};
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode[i]     <= (i == 0) ? MODE_BLINK : MODE_OFF;
        half[i]     <= (i == 0) ? DIV_W'(DEFAULT_HALF) : HALF_ONE;
        cnt[i]      <= '0;
        duty[i]     <= '0;
        phase[i]    <= 1'b0;
        dir_down[i] <= 1'b0;
      end
    end else begin
      cfg_ready <= 1'b1;
      pwm_cnt   <= pwm_cnt + DUTY_ONE;

      // tick is high for the single cycle following the prescaler wrap.
      if (pre_cnt == PRE_W'(PRESCALE - 1)) begin
        pre_cnt <= '0;
        tick    <= 1'b1;
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
        tick    <= 1'b0;
      end

      for (int i = 0; i < NUM_LEDS; i++) begin
        led[i] <= lit[i] ^ INACTIVE;

        // A config write takes priority over a coincident tick on that channel.
        if (cfg_hit[i]) begin
          mode[i]     <= mode_e'(cfg_mode);
          half[i]     <= cfg_half_eff;
          cnt[i]      <= '0;
          duty[i]     <= '0;
          phase[i]    <= 1'b0;
          dir_down[i] <= 1'b0;
        end else if (tick && (mode[i] == MODE_BLINK || mode[i] == MODE_BREATHE)) begin
          if (cnt[i] == half[i] - HALF_ONE) begin
            cnt[i]   <= '0;
            phase[i] <= ~phase[i];
            if (mode[i] == MODE_BREATHE) begin
              // Triangle walk 0..MAX..0; direction flips on arrival at an end.
              if (!dir_down[i]) begin
                duty[i] <= duty[i] + DUTY_ONE;
                if (duty[i] == DUTY_MAX - DUTY_ONE) dir_down[i] <= 1'b1;
              end else begin
                duty[i] <= duty[i] - DUTY_ONE;
                if (duty[i] == DUTY_ONE) dir_down[i] <= 1'b0;
              end
            end
          end else begin
            cnt[i] <= cnt[i] + HALF_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;

  localparam int N      = 6;
  localparam int PRE    = 10;
  localparam int DMAX   = 3;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_chan;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_half;
  logic        tick;
  logic [N-1:0] led;

  int checks = 0;
  int errors = 0;

  led_pattern_gen #(
    .NUM_LEDS(N), .CLK_HZ(100), .TICK_HZ(10), .DIV_W(16),
    .PWM_BITS(2), .DEFAULT_HALF(2), .ACTIVE_LOW(1)
  ) dut (
    .sys_clk(clk), .sys_reset_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_half(cfg_half), .tick(tick), .led(led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural reference model ----------------
  // Each channel is described by how many ticks it has consumed since its last
  // configuration; phase and duty follow arithmetically from that count.
  int          m_n;
  bit          m_tick;
  bit          m_ready;
  logic [N-1:0] m_led;
  int          m_mode  [N];
  int          m_half  [N];
  int          m_ticks [N];

  function automatic int tri_duty(input int steps);
    int k;
    k = steps % (2 * DMAX);
    return (k <= DMAX) ? k : (2 * DMAX - k);
  endfunction

  function automatic bit m_lit(input int c, input int pwm);
    case (m_mode[c])
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((m_ticks[c] / m_half[c]) % 2) == 1;
      default: return pwm < tri_duty(m_ticks[c] / m_half[c]);
    endcase
  endfunction

  always @(posedge clk) begin
    bit           tick_now;
    bit           acc;
    logic [N-1:0] nl;
    if (!rst_n) begin
      m_n = 0; m_tick = 0; m_ready = 0; m_led = '1;
      for (int c = 0; c < N; c++) begin
        m_mode[c]  = (c == 0) ? 2 : 0;
        m_half[c]  = (c == 0) ? 2 : 1;
        m_ticks[c] = 0;
      end
    end else begin
      tick_now = m_tick;
      acc      = cfg_valid && m_ready;
      for (int c = 0; c < N; c++) nl[c] = m_lit(c, m_n % 4) ^ 1'b1;
      m_led = nl;
      for (int c = 0; c < N; c++) begin
        if (acc && int'(cfg_chan) == c) begin
          m_mode[c]  = int'(cfg_mode);
          m_half[c]  = (cfg_half == 0) ? 1 : int'(cfg_half);
          m_ticks[c] = 0;
        end else if (tick_now) begin
          m_ticks[c] = m_ticks[c] + 1;
        end
      end
      m_n     = m_n + 1;
      m_tick  = (m_n % PRE) == 0;
      m_ready = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cfg_write(input int ch, input int md, input int hf);
    cfg_valid = 1'b1;
    cfg_chan  = 3'(ch);
    cfg_mode  = 2'(md);
    cfg_half  = 16'(hf);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (led !== 6'b111111) begin errors++; $display("FAIL reset_led got=%b exp=111111", led); end
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", cfg_ready); end
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", cfg_ready); end
  endtask

  task automatic test_ch0_blink;
    int t0, t1;
    logic prev;
    t0 = -1; t1 = -1; prev = led[0];
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      checks++;
      if (led !== m_led || tick !== m_tick || cfg_ready !== m_ready) begin
        errors++;
        $display("FAIL ch0_model cyc=%0d led=%b exp=%b tick=%b exp=%b", i, led, m_led, tick, m_tick);
      end
      checks++;
      if (led[5:1] !== 5'b11111) begin errors++; $display("FAIL ch0_others got=%b exp=11111", led[5:1]); end
      if (led[0] !== prev) begin
        if (t0 < 0) t0 = i; else if (t1 < 0) t1 = i;
        prev = led[0];
      end
    end
    checks++;
    if (t1 - t0 != 20) begin errors++; $display("FAIL ch0_period got=%0d exp=20", t1 - t0); end
  endtask

  task automatic test_tick;
    int n_ticks;
    bit prev;
    n_ticks = 0; prev = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (tick !== m_tick || led !== m_led) begin
        errors++;
        $display("FAIL tick_model cyc=%0d tick=%b exp=%b led=%b exp=%b", i, tick, m_tick, led, m_led);
      end
      checks++;
      if (prev && tick === 1'b1) begin errors++; $display("FAIL tick_double got=11 exp=no consecutive"); end
      if (tick === 1'b1) n_ticks++;
      prev = (tick === 1'b1);
    end
    checks++;
    if (n_ticks != 10) begin errors++; $display("FAIL tick_count got=%0d exp=10", n_ticks); end
  endtask

  task automatic test_blink_half(input int hf, input int exp_period);
    int t0, t1;
    logic prev;
    cfg_write(2, 2, hf);
    t0 = -1; t1 = -1; prev = led[2];
    for (int i = 1; i <= 4 * exp_period + 20 && t1 < 0; i++) begin
      @(negedge clk);
      checks++;
      if (led !== m_led || tick !== m_tick) begin
        errors++;
        $display("FAIL blink_model half=%0d cyc=%0d led=%b exp=%b", hf, i, led, m_led);
      end
      if (led[2] !== prev) begin
        if (t0 < 0) t0 = i; else t1 = i;
        prev = led[2];
      end
    end
    checks++;
    if (t0 < 0 || t1 < 0 || t1 - t0 != exp_period) begin
      errors++;
      $display("FAIL blink_period half=%0d got=%0d exp=%0d", hf, t1 - t0, exp_period);
    end
  endtask

  task automatic test_on_off_bad;
    cfg_write(1, 1, 5);
    checks++;
    if (led[1] !== 1'b1) begin errors++; $display("FAIL on_before got=%b exp=1", led[1]); end
    @(negedge clk);
    checks++;
    if (led[1] !== 1'b0) begin errors++; $display("FAIL on_after got=%b exp=0", led[1]); end
    cfg_write(1, 0, 5);
    @(negedge clk);
    checks++;
    if (led[1] !== 1'b1) begin errors++; $display("FAIL off_after got=%b exp=1", led[1]); end
    cfg_write(7, 1, 4);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      checks++;
      if (led !== m_led || cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL badchan led=%b exp=%b ready=%b exp=1", led, m_led, cfg_ready);
      end
    end
  endtask

  task automatic test_breathe;
    int guard, lows;
    cfg_write(3, 3, 1);
    for (int k = 1; k <= 8; k++) begin
      guard = 0;
      while (!m_tick && guard < 20) begin
        @(negedge clk);
        guard++;
        checks++;
        if (led !== m_led) begin errors++; $display("FAIL breathe_model led=%b exp=%b", led, m_led); end
      end
      checks++;
      if (guard >= 20) begin errors++; $display("FAIL breathe_tick_wait got=timeout exp=tick"); end
      @(negedge clk);
      lows = 0;
      for (int s = 0; s < 8; s++) begin
        @(negedge clk);
        if (led[3] === 1'b0) lows++;
        checks++;
        if (led !== m_led) begin errors++; $display("FAIL breathe_model led=%b exp=%b", led, m_led); end
      end
      checks++;
      if (lows != 2 * tri_duty(k)) begin
        errors++;
        $display("FAIL breathe_duty step=%0d got=%0d exp=%0d", k, lows / 2, tri_duty(k));
      end
    end
  endtask

  task automatic test_collision;
    int guard, ones;
    guard = 0;
    while (!m_tick && guard < 20) begin @(negedge clk); guard++; end
    cfg_write(2, 2, 1);
    ones = 0;
    guard = 0;
    @(negedge clk);
    while (led[2] === 1'b1 && guard < 30) begin
      ones++; guard++;
      checks++;
      if (led !== m_led) begin errors++; $display("FAIL collide_model led=%b exp=%b", led, m_led); end
      @(negedge clk);
    end
    checks++;
    if (ones != 10) begin errors++; $display("FAIL collide_drop got=%0d exp=10", ones); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (led !== m_led || tick !== m_tick) begin
        errors++;
        $display("FAIL collide_after led=%b exp=%b", led, m_led);
      end
    end
  endtask

  task automatic test_mid_reset;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (led !== 6'b111111 || cfg_ready !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL midreset led=%b exp=111111 ready=%b exp=0 tick=%b exp=0", led, cfg_ready, tick);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (led !== m_led || tick !== m_tick || cfg_ready !== m_ready) begin
        errors++;
        $display("FAIL midreset_model cyc=%0d led=%b exp=%b", i, led, m_led);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if (led !== m_led || tick !== m_tick || cfg_ready !== m_ready) begin
        errors++;
        $display("FAIL random_model cyc=%0d led=%b exp=%b tick=%b exp=%b", i, led, m_led, tick, m_tick);
      end
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_chan  = 3'($urandom_range(0, 7));
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_half  = 16'($urandom_range(0, 3));
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_mode  = '0;
    cfg_half  = '0;
    test_reset();
    test_ch0_blink();
    test_tick();
    test_blink_half(3, 30);
    test_blink_half(0, 10);
    test_on_off_bad();
    test_breathe();
    test_collision();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
